// File: rtl/mdl_memory_mp.sv
// Multi-port word memory with byte-lane writes, NRD independent 1-cycle read
// ports with write-through bypass, a sticky address-error flag and a
// sequential clear engine that zeroes the array after reset or on request.
module mdl_memory_mp #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 16,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int NB    = WIDTH / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_req,
    output logic                 busy,
    input  logic                 vld_in,
    input  logic [AW-1:0]        wr_addr,
    input  logic [NB-1:0]        wr_be,
    input  logic [WIDTH-1:0]     data_in,
    input  logic [NRD-1:0]       vld_out,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] data_out,
    output logic [NRD-1:0]       rd_vld,
    output logic                 addr_err
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Address-space bounds; the AW-bit address can exceed DEPTH-1 when DEPTH
    // is not a power of two, so range checks use one extra bit.
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t                 state_q;
    logic [AW-1:0]          clr_ptr_q;
    logic [WIDTH-1:0]       mem [DEPTH];

    logic [NRD-1:0]         rd_vld_q, rd_vld_d;
    logic [NRD*WIDTH-1:0]   data_out_q, data_out_d;
    logic                   addr_err_q;

    logic                   wr_in_range;
    logic                   wr_acc;
    logic                   wr_err;
    logic                   rd_err;
    logic [AW-1:0]          rd_a;
    logic [WIDTH-1:0]       rd_word;

    // Replace the enabled byte lanes of old_w with those of new_w.
    function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0] old_w,
                                                     input logic [WIDTH-1:0] new_w,
                                                     input logic [NB-1:0]    be);
        merge_lanes = old_w;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) merge_lanes[8*b +: 8] = new_w[8*b +: 8];
        end
    endfunction

    assign busy        = (state_q == ST_CLEAR);
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    assign wr_acc      = vld_in && !busy && wr_in_range;
    assign wr_err      = vld_in && !busy && !wr_in_range;

    // Clear engine: walk clr_ptr across the array, then idle until clr_req.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (clr_ptr_q == LAST) state_q   <= ST_IDLE;
                    else                   clr_ptr_q <= clr_ptr_q + 1'b1;
                end
                ST_IDLE: begin
                    if (clr_req) begin
                        state_q   <= ST_CLEAR;
                        clr_ptr_q <= '0;
                    end
                end
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

    // Array update: zero one word per cycle while clearing, else byte-lane write.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; its contents are zeroed only by the
        // clear walk, which keeps it mappable onto plain RAM.
        if (rst) begin
            if (state_q == ST_CLEAR) begin
                mem[clr_ptr_q] <= '0;
            end else if (wr_acc) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_be[b]) mem[wr_addr][8*b +: 8] <= data_in[8*b +: 8];
                end
            end
        end
    end

    // Read ports: look up, apply same-cycle write bypass, flag out-of-range.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        rd_vld_d   = '0;
        data_out_d = data_out_q;
        rd_err     = 1'b0;
        rd_a       = '0;
        rd_word    = '0;
        for (int k = 0; k < NRD; k++) begin
            if (vld_out[k] && !busy) begin
                rd_a        = rd_addr[k*AW +: AW];
                rd_vld_d[k] = 1'b1;
                if ({1'b0, rd_a} < DEPTH_W) begin
                    rd_word = mem[rd_a];
                    if (wr_acc && (wr_addr == rd_a)) begin
                        rd_word = merge_lanes(rd_word, data_in, wr_be);
                    end
                    data_out_d[k*WIDTH +: WIDTH] = rd_word;
                end else begin
                    data_out_d[k*WIDTH +: WIDTH] = '0;
                    rd_err                       = 1'b1;
                end
            end
        end
    end

    // Registered read outputs and sticky address-error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_vld_q   <= '0;
            data_out_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            rd_vld_q   <= rd_vld_d;
            data_out_q <= data_out_d;
            if (wr_err || rd_err) addr_err_q <= 1'b1;
        end
    end

    assign rd_vld   = rd_vld_q;
    assign data_out = data_out_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_mdl_memory_mp.sv
// Self-checking bench for mdl_memory_mp: a DEPTH=16 instance tracked by a
// cycle-level reference model plus hand constants, and a DEPTH=12 instance
// for out-of-range behaviour.
module tb_mdl_memory_mp;

    logic        clk;
    logic        rst;

    // DEPTH=16 instance
    logic        clr_req, busy, vld_in, addr_err;
    logic [3:0]  wr_addr;
    logic [1:0]  wr_be;
    logic [15:0] data_in;
    logic [1:0]  vld_out, rd_vld;
    logic [7:0]  rd_addr;
    logic [31:0] data_out;

    // DEPTH=12 instance
    logic        x_clr_req, x_busy, x_vld_in, x_addr_err;
    logic [3:0]  x_wr_addr;
    logic [1:0]  x_wr_be;
    logic [15:0] x_data_in;
    logic [1:0]  x_vld_out, x_rd_vld;
    logic [7:0]  x_rd_addr;
    logic [31:0] x_data_out;

    int n_checks = 0;
    int n_errors = 0;

    mdl_memory_mp #(.DEPTH(16), .WIDTH(16), .NRD(2)) u_dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
        .vld_in(vld_in), .wr_addr(wr_addr), .wr_be(wr_be), .data_in(data_in),
        .vld_out(vld_out), .rd_addr(rd_addr), .data_out(data_out),
        .rd_vld(rd_vld), .addr_err(addr_err)
    );

    mdl_memory_mp #(.DEPTH(12), .WIDTH(16), .NRD(2)) u_dut12 (
        .clk(clk), .rst(rst), .clr_req(x_clr_req), .busy(x_busy),
        .vld_in(x_vld_in), .wr_addr(x_wr_addr), .wr_be(x_wr_be), .data_in(x_data_in),
        .vld_out(x_vld_out), .rd_addr(x_rd_addr), .data_out(x_data_out),
        .rd_vld(x_rd_vld), .addr_err(x_addr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model (DEPTH=16 instance) ----------------
    logic [15:0] m_mem [16];
    int          m_clr_left = 16;
    logic [1:0]  m_vld;
    logic [15:0] m_dout [2];
    logic        m_err;

    function automatic logic [15:0] merge16(input logic [15:0] old_w,
                                            input logic [15:0] new_w,
                                            input logic [1:0]  be);
        logic [15:0] r;
        r = old_w;
        if (be[0]) r[7:0]  = new_w[7:0];
        if (be[1]) r[15:8] = new_w[15:8];
        return r;
    endfunction

    // Apply one clock edge's worth of behaviour to the model, using the
    // inputs currently driven. A clear zeroes the model array at once:
    // nothing can observe it before the busy window ends.
    task automatic model_edge();
        logic [3:0]  a;
        logic [15:0] w;
        if (!rst) begin
            m_clr_left = 16;
            m_vld      = 2'b00;
            m_dout[0]  = '0;
            m_dout[1]  = '0;
            m_err      = 1'b0;
            for (int i = 0; i < 16; i++) m_mem[i] = '0;
        end else if (m_clr_left > 0) begin
            m_clr_left = m_clr_left - 1;
            m_vld      = 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_vld[k] = vld_out[k];
                if (vld_out[k]) begin
                    a = rd_addr[k*4 +: 4];
                    w = m_mem[a];
                    if (vld_in && wr_addr == a) w = merge16(w, data_in, wr_be);
                    m_dout[k] = w;
                end
            end
            if (vld_in) m_mem[wr_addr] = merge16(m_mem[wr_addr], data_in, wr_be);
            if (clr_req) begin
                m_clr_left = 16;
                for (int i = 0; i < 16; i++) m_mem[i] = '0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: update model, wait for the edge, compare away from it.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("model_busy", {31'd0, busy}, {31'd0, (m_clr_left > 0)});
        check("model_rd_vld", {30'd0, rd_vld}, {30'd0, m_vld});
        check("model_dout0", {16'd0, data_out[15:0]}, {16'd0, m_dout[0]});
        check("model_dout1", {16'd0, data_out[31:16]}, {16'd0, m_dout[1]});
        check("model_addr_err", {31'd0, addr_err}, {31'd0, m_err});
    endtask

    task automatic set_idle();
        clr_req = 1'b0; vld_in = 1'b0; wr_addr = '0; wr_be = '0; data_in = '0;
        vld_out = 2'b00; rd_addr = '0;
        x_clr_req = 1'b0; x_vld_in = 1'b0; x_wr_addr = '0; x_wr_be = '0;
        x_data_in = '0; x_vld_out = 2'b00; x_rd_addr = '0;
    endtask

    // Count busy cycles (current one included) until busy drops, bounded.
    task automatic count_busy(output int cnt, input int pulse_at);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            clr_req = (cnt == pulse_at);
            step();
        end
        clr_req = 1'b0;
    endtask

    // Read every DEPTH=16 address and compare with zero.
    task automatic sweep_zero(input string name);
        for (int a = 0; a < 8; a++) begin
            set_idle();
            vld_out = 2'b11;
            rd_addr = {4'(2*a+1), 4'(2*a)};
            step();
            check(name, data_out, 32'h0);
        end
        set_idle();
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [1:0]  be;
        logic [15:0] wd;
        logic [1:0]  re;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic [1:0]  exp_vld;
        logic [15:0] exp0;
        logic [15:0] exp1;
    } vec_t;

    vec_t vecs [9];

    int cnt;

    initial begin
        //             we  wa     be     wd        re     ra0    ra1    vld    exp0      exp1
        vecs[0] = '{1'b1, 4'd3, 2'b11, 16'hABCD, 2'b00, 4'd0, 4'd0, 2'b00, 16'h0000, 16'h0000};
        vecs[1] = '{1'b1, 4'd3, 2'b01, 16'h1234, 2'b00, 4'd0, 4'd0, 2'b00, 16'h0000, 16'h0000};
        vecs[2] = '{1'b0, 4'd0, 2'b00, 16'h0000, 2'b01, 4'd3, 4'd0, 2'b01, 16'hAB34, 16'h0000};
        vecs[3] = '{1'b1, 4'd5, 2'b10, 16'hBEEF, 2'b11, 4'd5, 4'd5, 2'b11, 16'hBE00, 16'hBE00};
        vecs[4] = '{1'b0, 4'd0, 2'b00, 16'h0000, 2'b11, 4'd5, 4'd3, 2'b11, 16'hBE00, 16'hAB34};
        vecs[5] = '{1'b1, 4'd7, 2'b00, 16'hCAFE, 2'b01, 4'd7, 4'd0, 2'b01, 16'h0000, 16'h0000};
        vecs[6] = '{1'b1, 4'd7, 2'b11, 16'h1111, 2'b10, 4'd0, 4'd7, 2'b10, 16'h0000, 16'h1111};
        vecs[7] = '{1'b0, 4'd0, 2'b00, 16'h0000, 2'b11, 4'd7, 4'd7, 2'b11, 16'h1111, 16'h1111};
        vecs[8] = '{1'b0, 4'd0, 2'b00, 16'h0000, 2'b00, 4'd0, 4'd0, 2'b00, 16'h0000, 16'h0000};

        set_idle();
        rst = 1'b0;
        step();
        step();
        check("reset_busy", {31'd0, busy}, 32'd1);
        check("reset_rd_vld", {30'd0, rd_vld}, 32'd0);
        check("reset_dout", data_out, 32'd0);
        check("reset_addr_err", {31'd0, addr_err}, 32'd0);

        // Release reset and write immediately: writes must be ignored.
        rst = 1'b1;
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            vld_in = 1'b1; wr_addr = 4'(cnt - 1); wr_be = 2'b11;
            data_in = 16'($urandom) | 16'h0001;
            vld_out = 2'b11; rd_addr = 8'h21;
            step();
            check("busy_rd_vld", {30'd0, rd_vld}, 32'd0);
        end
        set_idle();
        check("post_reset_busy_len", cnt, 16);
        sweep_zero("post_reset_zero");

        // Table-driven vectors.
        for (int i = 0; i < 9; i++) begin
            set_idle();
            vld_in = vecs[i].we; wr_addr = vecs[i].wa; wr_be = vecs[i].be;
            data_in = vecs[i].wd; vld_out = vecs[i].re;
            rd_addr = {vecs[i].ra1, vecs[i].ra0};
            step();
            check($sformatf("vec%0d_rd_vld", i), {30'd0, rd_vld}, {30'd0, vecs[i].exp_vld});
            if (vecs[i].exp_vld[0])
                check($sformatf("vec%0d_dout0", i), {16'd0, data_out[15:0]}, {16'd0, vecs[i].exp0});
            if (vecs[i].exp_vld[1])
                check($sformatf("vec%0d_dout1", i), {16'd0, data_out[31:16]}, {16'd0, vecs[i].exp1});
        end
        set_idle();
        check("hold_dout", data_out, 32'h1111_1111);

        // Fill, clear, and a second clear pulse 4 cycles later is ignored.
        for (int a = 0; a < 16; a++) begin
            set_idle();
            vld_in = 1'b1; wr_addr = 4'(a); wr_be = 2'b11; data_in = 16'(a * 16'h1111 + 1);
            step();
        end
        set_idle();
        clr_req = 1'b1;
        step();
        check("clr_busy_start", {31'd0, busy}, 32'd1);
        count_busy(cnt, 4);
        check("clr_busy_len", cnt, 16);
        step();
        step();
        check("clr_no_requeue", {31'd0, busy}, 32'd0);
        sweep_zero("clr_zero");

        // Reset asserted at clr_ptr=7 during a clear restarts the walk.
        vld_in = 1'b1; wr_addr = 4'd9; wr_be = 2'b11; data_in = 16'h9999;
        step();
        set_idle();
        clr_req = 1'b1;
        step();
        for (int i = 0; i < 7; i++) step();
        check("mid_clear_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        count_busy(cnt, 0);
        check("restart_busy_len", cnt, 16);
        sweep_zero("restart_zero");

        // DEPTH=12 instance: out-of-range write and read.
        set_idle();
        x_vld_in = 1'b1; x_wr_addr = 4'd1; x_wr_be = 2'b11; x_data_in = 16'h5555;
        step();
        set_idle();
        x_vld_out = 2'b11; x_rd_addr = {4'd1, 4'd0};
        step();
        check("d12_rd_vld", {30'd0, x_rd_vld}, 32'd3);
        check("d12_dout1", {16'd0, x_data_out[31:16]}, 32'h5555);
        check("d12_err_before", {31'd0, x_addr_err}, 32'd0);
        set_idle();
        x_vld_in = 1'b1; x_wr_addr = 4'd13; x_wr_be = 2'b11; x_data_in = 16'hFFFF;
        x_vld_out = 2'b10; x_rd_addr = {4'd14, 4'd0};
        step();
        check("d12_oor_rd_vld", {30'd0, x_rd_vld}, 32'd2);
        check("d12_oor_dout1", {16'd0, x_data_out[31:16]}, 32'd0);
        check("d12_oor_err", {31'd0, x_addr_err}, 32'd1);
        set_idle();
        for (int i = 0; i < 3; i++) step();
        check("d12_err_held", {31'd0, x_addr_err}, 32'd1);
        check("d12_idle_rd_vld", {30'd0, x_rd_vld}, 32'd0);
        for (int a = 0; a < 6; a++) begin
            set_idle();
            x_vld_out = 2'b11; x_rd_addr = {4'(2*a+1), 4'(2*a)};
            step();
            check("d12_sweep0", {16'd0, x_data_out[15:0]}, 32'd0);
            check("d12_sweep1", {16'd0, x_data_out[31:16]}, (a == 0) ? 32'h5555 : 32'd0);
        end
        set_idle();

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            clr_req = ($urandom_range(0, 49) == 0);
            vld_in  = 1'($urandom);
            wr_addr = 4'($urandom);
            wr_be   = 2'($urandom);
            data_in = 16'($urandom);
            vld_out = 2'($urandom);
            rd_addr = ($urandom_range(0, 3) == 0) ? {2{wr_addr}} : 8'($urandom);
            step();
        end
        set_idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mdl_memory_mp.md
MDL_MEMORY_MP -- requirements
Module: mdl_memory_mp

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the number of words (any value >= 2, not limited to powers of two).
REQ-002 The block SHALL have parameter WIDTH, default 16, giving the word width in bits (a multiple of 8).
REQ-003 The block SHALL have parameter NRD, default 2, giving the number of independent read ports.
REQ-004 Derived widths SHALL be AW = $clog2(DEPTH) and NB = WIDTH/8.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-007 The block SHALL have port clr_req, input, 1 bit: request to zero the whole array.
REQ-008 The block SHALL have port busy, output, 1 bit: clear sequence in progress.
REQ-009 The block SHALL have port vld_in, input, 1 bit: write request.
REQ-010 The block SHALL have port wr_addr, input, AW bits: write address.
REQ-011 The block SHALL have port wr_be, input, NB bits: byte enables; bit b covers data_in[8b+7:8b].
REQ-012 The block SHALL have port data_in, input, WIDTH bits: write data.
REQ-013 The block SHALL have port vld_out, input, NRD bits: per-port read request.
REQ-014 The block SHALL have port rd_addr, input, NRD*AW bits: port k address at [k*AW +: AW].
REQ-015 The block SHALL have port data_out, output, NRD*WIDTH bits: port k data at [k*WIDTH +: WIDTH].
REQ-016 The block SHALL have port rd_vld, output, NRD bits: port k data_out valid this cycle.
REQ-017 The block SHALL have port addr_err, output, 1 bit: sticky flag set by any accepted out-of-range address.

Function
REQ-018 The block SHALL implement a 2-state FSM: CLEAR and IDLE.
REQ-019 In CLEAR, the block SHALL write zero to mem[clr_ptr] each cycle and increment clr_ptr; on the cycle clr_ptr == DEPTH-1, it SHALL return to IDLE on the next edge.
REQ-020 busy SHALL be 1 exactly while in CLEAR, i.e. for DEPTH consecutive cycles per clear.
REQ-021 In IDLE, clr_req=1 SHALL move the FSM to CLEAR with clr_ptr=0 on the next edge; any write or read presented in that same cycle SHALL still be serviced.
REQ-022 clr_req asserted while busy SHALL be ignored (no restart, no queuing).
REQ-023 A write SHALL be accepted when vld_in=1, busy=0 and wr_addr < DEPTH; each byte lane with wr_be[b]=1 updates at the edge, and lanes with wr_be[b]=0 keep their contents.
REQ-024 A write with wr_be = 0 SHALL be accepted but SHALL change nothing.
REQ-025 A read on port k SHALL be accepted when vld_out[k]=1 and busy=0; read latency SHALL be 1 cycle: rd_vld[k]=1 and data_out[k] valid on the cycle after acceptance.
REQ-026 Write-through bypass: when an accepted read and an accepted write hit the same address in the same cycle, data_out SHALL return the merged word (enabled lanes from data_in, other lanes from the old content), independently per port.
REQ-027 Read ports SHALL be fully independent; identical addresses on several ports SHALL return identical data.
REQ-028 An out-of-range write (wr_addr >= DEPTH, vld_in=1, busy=0) SHALL leave the array unchanged and set addr_err.
REQ-029 An out-of-range read on port k SHALL produce rd_vld[k]=1 with data_out[k]=0 and set addr_err.
REQ-030 With no accepted read on port k, rd_vld[k] SHALL be 0 and data_out[k] SHALL hold its last value.
REQ-031 While busy, vld_in and vld_out SHALL be ignored: no array update, rd_vld=0, addr_err unchanged.
REQ-032 addr_err SHALL clear only on reset.

Reset
REQ-033 While rst=0 at a clock edge: FSM=CLEAR, clr_ptr=0, busy=1, rd_vld=0, data_out=0, addr_err=0.
REQ-034 After rst returns to 1, the block SHALL run a full clear: busy stays 1 for DEPTH cycles, then drops to 0 with every word equal to 0.
REQ-035 Reset asserted mid-CLEAR or mid-traffic SHALL restart the clear from address 0; in-flight reads SHALL be discarded.
REQ-036 The array itself SHALL not require a reset port; zeroing SHALL be done only by the CLEAR sequence.

Verification (DEPTH=16, WIDTH=16, NRD=2)
REQ-037 Release rst, then drive writes immediately -> busy=1 for 16 cycles, writes ignored; all 16 addresses then read 0x0000.
REQ-038 Write 0xABCD to address 3 with be=11, then be=01 with 0x1234 -> a following read of address 3 returns 0xAB34 with rd_vld=1 one cycle after the request.
REQ-039 With address 5 holding 0x0000, write 0xBEEF to address 5 with be=10 while port0 and port1 both read address 5 in the same cycle -> both ports return 0xBE00 next cycle.
REQ-040 With DEPTH=12, write address 13 and read address 14 on port1 -> array unchanged, rd_vld[1]=1, data_out[1]=0, addr_err=1 and held.
REQ-041 Fill the array, pulse clr_req, pulse it again 4 cycles later -> exactly one 16-cycle busy window, the second pulse is ignored, and all words read 0.
REQ-042 Assert rst at clr_ptr=7 during a clear -> the clear restarts at 0, with busy high for 16 cycles after release.
